spi_flash_op_sched: RTL
=======================

// Module: spi_flash_op_sched
// PURPOSE
// Operation scheduler for the SPI byte master (spi_start/spi_end/data_send/send_done interface).
// Turns one user request (sector erase, page program, read) into the full flash command sequence:
// WREN, command, 24-bit address, data phase, then RDSR polling until WIP clears.
// Sits between user logic (FWFT write FIFO, read sink) and the SPI byte master, replacing fixed-sequence controllers.
// PARAMETERS
// WAIT_PWRUP  100    cycles after reset before the first command is accepted
// CS_GAP      10     idle cycles between spi_end and the next spi_start (>=200ns at 50MHz)
// POLL_LIMIT  50000  max RDSR polls before the operation is aborted with op_err
// PORTS
// sys_clk      in   1   system clock, 50MHz
// sys_rst_n    in   1   synchronous reset, active low
// op_start     in   1   request pulse; sampled only when op_busy=0
// op_type      in   2   0=sector erase (0xD8), 1=page program (0x02), 2=read (0x03), 3=reserved
// op_addr      in   24  flash byte address, sent MSB byte first
// op_len       in   9   byte count for program/read, 1..256 (0 is treated as 1)
// wdata        in   8   program data, FWFT; must be valid whenever wdata_pop can fire
// wdata_pop    out  1   1-cycle pulse: wdata consumed
// rdata        out  8   read byte
// rdata_valid  out  1   1-cycle pulse: rdata valid
// op_busy      out  1   high from reset through power-up wait, and from op_start until op_done
// op_done      out  1   1-cycle pulse at operation end
// op_err       out  1   1-cycle pulse together with op_done on poll timeout or reserved op_type
// send_done    in   1   byte master: current byte finished; data_rec valid this cycle
// data_rec     in   8   byte master: byte shifted in during the finished byte
// spi_start    out  1   1-cycle pulse: assert CS, send data_send
// spi_end      out  1   1-cycle pulse: release CS after the current byte
// data_send    out  8   byte to transmit; updated in the send_done cycle, and the master sends it next
// BEHAVIOUR
// Reset (sync, sys_rst_n=0 at a clock edge): every output is 0, state=PWRUP, all counters and captured request fields are 0.
// Reset mid-operation aborts immediately: no spi_end and no op_done are issued. The byte master shares the same reset.
// op_start, op_type, op_addr and op_len are captured in the op_start cycle (IDLE only). op_start is ignored while busy.
// States and transitions:
//   PWRUP    count WAIT_PWRUP cycles -> IDLE.
//   IDLE     op_start: type 3 -> ERR (op_done+op_err next cycle); type 2 -> CMD; else -> WREN. op_busy rises next cycle.
//   WREN     spi_start with data_send=0x06 -> WREN_W. WREN_W: on send_done, spi_end -> GAP (then CMD).
//   CMD      spi_start with data_send=cmd -> ADDR. ADDR: each send_done loads the next address byte [23:16], [15:8], [7:0].
//   ADDR     on send_done of the last address byte:
//            erase: spi_end, then GAP -> POLL.
//            program: pop wdata into data_send -> DATA.
//            read: data_send=0x00 -> DATA.
//   DATA     on each send_done, byte counter += 1.
//            program: pop next wdata; on the op_len-th byte, spi_end with no pop, then GAP -> POLL.
//            read: rdata=data_rec and rdata_valid (the first send_done in DATA is the first data byte); on the op_len-th byte, spi_end, then GAP -> DONE.
//   GAP      CS_GAP+1 cycles idle, then the next state.
//   POLL     spi_start with 0x05; on send_done, data_send=0x00; on the 2nd send_done, spi_end and test data_rec[0]:
//            1 -> poll_cnt += 1, GAP -> POLL; 0 -> DONE; poll_cnt==POLL_LIMIT -> ERR.
//   DONE/ERR op_done (plus op_err in ERR) for one cycle, op_busy=0 in the same cycle -> IDLE.
// A page program is not split at page boundaries; the flash wraps within the page.
// spi_start and spi_end are never high in the same cycle.
// Back-to-back op_start in the op_done cycle is accepted, because op_busy is already 0.
// TESTING
// 1) Reset then wait: op_busy=1 for WAIT_PWRUP cycles, then 0; a spi_start before that is a failure.
// 2) Program addr=0x012345, len=3, FIFO holds A0/A1/A2 -> MOSI bytes 06 | 02 01 23 45 A0 A1 A2 | 05 00, 3 pops, op_done.
// 3) Erase addr=0x040000, BFM returns status 01,01,00 -> 06 | D8 04 00 00 | three RDSR frames, op_done, op_err=0.
// 4) Read addr=0x000010, len=2, BFM returns 5A,C3 -> 03 00 00 10 00 00, rdata_valid twice with 5A then C3, no WREN or RDSR.
// 5) POLL_LIMIT=3 with WIP stuck at 1 -> 3 polls then a 4th decision gives op_done+op_err; op_type=3 -> op_done+op_err 2 cycles after op_start.
// 6) Reset asserted during DATA, and op_start while busy -> outputs 0 and no op_done; the busy-time op_start has no effect.

Source files
------------

// File: rtl/spi_flash_op_sched.sv
// Flash operation scheduler: expands one erase/program/read request into the
// WREN / command / address / data / RDSR-poll byte sequence for an SPI byte master.
module spi_flash_op_sched #(
   parameter int unsigned WAIT_PWRUP = 100,
   parameter int unsigned CS_GAP     = 10,
   parameter int unsigned POLL_LIMIT = 50000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        op_start,
   input  logic [1:0]  op_type,
   input  logic [23:0] op_addr,
   input  logic [8:0]  op_len,
   input  logic [7:0]  wdata,
   output logic        wdata_pop,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        op_busy,
   output logic        op_done,
   output logic        op_err,
   input  logic        send_done,
   input  logic [7:0]  data_rec,
   output logic        spi_start,
   output logic        spi_end,
   output logic [7:0]  data_send
);

   localparam int unsigned CNT_MAX = (WAIT_PWRUP > CS_GAP) ? WAIT_PWRUP : CS_GAP;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam int unsigned POLL_W  = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);
   localparam int unsigned LEN_W   = 9;

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_ERASE = 8'hD8;
   localparam logic [7:0] OP_PROG  = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;

   localparam logic [1:0] T_ERASE = 2'd0;
   localparam logic [1:0] T_PROG  = 2'd1;
   localparam logic [1:0] T_READ  = 2'd2;
   localparam logic [1:0] T_RSVD  = 2'd3;

   typedef enum logic [3:0] {
      S_PWRUP, S_IDLE, S_WREN, S_WREN_W, S_CMD, S_ADDR,
      S_DATA, S_GAP, S_POLL, S_POLL_W, S_DONE, S_ERR
   } state_e;

   state_e             state_q, state_d;
   state_e             gap_next_q, gap_next_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
   logic               poll_ph_q, poll_ph_d;
   logic [1:0]         type_q, type_d;
   logic [23:0]        addr_q, addr_d;
   logic [LEN_W-1:0]   len_q, len_d;

   logic               spi_start_q, spi_start_d;
   logic               spi_end_q, spi_end_d;
   logic [7:0]         data_send_q, data_send_d;
   logic               wdata_pop_q, wdata_pop_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               rdata_valid_q, rdata_valid_d;
   logic               op_busy_q, op_busy_d;
   logic               op_done_q, op_done_d;
   logic               op_err_q, op_err_d;

   logic [7:0]         cmd_byte;
   logic [LEN_W-1:0]   byte_inc;

   // State and output registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q       <= S_PWRUP;
         gap_next_q    <= S_PWRUP;
         cnt_q         <= '0;
         byte_cnt_q    <= '0;
         poll_cnt_q    <= '0;
         poll_ph_q     <= 1'b0;
         type_q        <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         spi_start_q   <= 1'b0;
         spi_end_q     <= 1'b0;
         data_send_q   <= '0;
         wdata_pop_q   <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         op_busy_q     <= 1'b0;
         op_done_q     <= 1'b0;
         op_err_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_next_q    <= gap_next_d;
         cnt_q         <= cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         poll_cnt_q    <= poll_cnt_d;
         poll_ph_q     <= poll_ph_d;
         type_q        <= type_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         spi_start_q   <= spi_start_d;
         spi_end_q     <= spi_end_d;
         data_send_q   <= data_send_d;
         wdata_pop_q   <= wdata_pop_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         op_busy_q     <= op_busy_d;
         op_done_q     <= op_done_d;
         op_err_q      <= op_err_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      gap_next_d    = gap_next_q;
      cnt_d         = cnt_q;
      byte_cnt_d    = byte_cnt_q;
      poll_cnt_d    = poll_cnt_q;
      poll_ph_d     = poll_ph_q;
      type_d        = type_q;
      addr_d        = addr_q;
      len_d         = len_q;
      spi_start_d   = 1'b0;
      spi_end_d     = 1'b0;
      data_send_d   = data_send_q;
      wdata_pop_d   = 1'b0;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      op_done_d     = 1'b0;
      op_err_d      = 1'b0;
      byte_inc      = byte_cnt_q + LEN_W'(1);

      case (type_q)
         T_ERASE: cmd_byte = OP_ERASE;
         T_PROG:  cmd_byte = OP_PROG;
         default: cmd_byte = OP_READ;
      endcase

      case (state_q)
         S_PWRUP: begin
            if (cnt_q == CNT_W'(WAIT_PWRUP)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IDLE: begin
            if (op_start) begin
               type_d     = op_type;
               addr_d     = op_addr;
               len_d      = (op_len == '0) ? LEN_W'(1) : op_len;
               poll_cnt_d = '0;
               byte_cnt_d = '0;
               case (op_type)
                  T_RSVD:  state_d = S_ERR;
                  T_READ:  state_d = S_CMD;
                  default: state_d = S_WREN;
               endcase
            end
         end
         S_WREN: begin
            spi_start_d = 1'b1;
            data_send_d = OP_WREN;
            state_d     = S_WREN_W;
         end
         S_WREN_W: begin
            if (send_done) begin
               spi_end_d  = 1'b1;
               gap_next_d = S_CMD;
               cnt_d      = '0;
               state_d    = S_GAP;
            end
         end
         S_CMD: begin
            spi_start_d = 1'b1;
            data_send_d = cmd_byte;
            byte_cnt_d  = '0;
            state_d     = S_ADDR;
         end
         S_ADDR: begin
            // byte_cnt_q counts completed bytes of the frame: 0 = command done
            if (send_done) begin
               case (byte_cnt_q)
                  LEN_W'(0): begin data_send_d = addr_q[23:16]; byte_cnt_d = byte_inc; end
                  LEN_W'(1): begin data_send_d = addr_q[15:8];  byte_cnt_d = byte_inc; end
                  LEN_W'(2): begin data_send_d = addr_q[7:0];   byte_cnt_d = byte_inc; end
                  default: begin
                     byte_cnt_d = '0;
                     if (type_q == T_ERASE) begin
                        spi_end_d  = 1'b1;
                        gap_next_d = S_POLL;
                        cnt_d      = '0;
                        state_d    = S_GAP;
                     end else if (type_q == T_PROG) begin
                        data_send_d = wdata;
                        wdata_pop_d = 1'b1;
                        state_d     = S_DATA;
                     end else begin
                        data_send_d = 8'h00;
                        state_d     = S_DATA;
                     end
                  end
               endcase
            end
         end
         S_DATA: begin
            if (send_done) begin
               byte_cnt_d = byte_inc;
               if (type_q == T_READ) begin
                  rdata_d       = data_rec;
                  rdata_valid_d = 1'b1;
               end
               if (byte_inc == len_q) begin
                  spi_end_d  = 1'b1;
                  byte_cnt_d = '0;
                  gap_next_d = (type_q == T_READ) ? S_DONE : S_POLL;
                  cnt_d      = '0;
                  state_d    = S_GAP;
               end else if (type_q == T_PROG) begin
                  data_send_d = wdata;
                  wdata_pop_d = 1'b1;
               end else begin
                  data_send_d = 8'h00;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(CS_GAP)) begin
               cnt_d   = '0;
               state_d = gap_next_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_POLL: begin
            spi_start_d = 1'b1;
            data_send_d = OP_RDSR;
            poll_ph_d   = 1'b0;
            state_d     = S_POLL_W;
         end
         S_POLL_W: begin
            // Phase 0 finishes the opcode byte, phase 1 returns the status byte
            if (send_done) begin
               if (!poll_ph_q) begin
                  data_send_d = 8'h00;
                  poll_ph_d   = 1'b1;
               end else begin
                  spi_end_d = 1'b1;
                  poll_ph_d = 1'b0;
                  if (!data_rec[0]) begin
                     state_d = S_DONE;
                  end else if (poll_cnt_q == POLL_W'(POLL_LIMIT)) begin
                     state_d = S_ERR;
                  end else begin
                     poll_cnt_d = poll_cnt_q + POLL_W'(1);
                     gap_next_d = S_POLL;
                     cnt_d      = '0;
                     state_d    = S_GAP;
                  end
               end
            end
         end
         S_DONE: begin
            op_done_d = 1'b1;
            state_d   = S_IDLE;
         end
         S_ERR: begin
            op_done_d = 1'b1;
            op_err_d  = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      op_busy_d = (state_d != S_IDLE);
   end

   assign spi_start   = spi_start_q;
   assign spi_end     = spi_end_q;
   assign data_send   = data_send_q;
   assign wdata_pop   = wdata_pop_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign op_busy     = op_busy_q;
   assign op_done     = op_done_q;
   assign op_err      = op_err_q;

endmodule
